// File: rtl/frame_assembler.sv
// Byte-stream packer feeding the CRC engine: collects a packet into a wide word,
// launches the CRC, and forwards its result and length downstream.
module frame_assembler #(
    parameter int MAX_BYTES = 40,
    parameter int TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    input  logic                   in_sop,
    input  logic                   in_eop,
    output logic                   in_ready,
    output logic                   crc_valid,
    output logic [8*MAX_BYTES-1:0] data_raw,
    input  logic                   crc_done,
    input  logic [31:0]            crc_in,
    output logic                   res_valid,
    output logic [31:0]            res_crc,
    output logic [5:0]             res_len,
    output logic                   err
);

    localparam int DW = 8 * MAX_BYTES;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DROP,
        ISSUE,
        WAIT_CRC
    } state_t;

    state_t        state;
    state_t        next;
    logic [5:0]    cnt;
    logic [TW-1:0] tcnt;
    logic          accept;
    logic          full;
    logic          expire;
    logic          load;
    logic          shift;

    assign in_ready  = (state != ISSUE) && (state != WAIT_CRC);
    assign crc_valid = (state == ISSUE);
    assign accept    = in_valid && in_ready;
    assign full      = (cnt == 6'(MAX_BYTES));
    assign expire    = (tcnt == TW'(TIMEOUT - 1));
    assign load      = accept && in_sop;
    assign shift     = accept && !in_sop && (state == COLLECT) && !full;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        err  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && in_sop)
                    next = in_eop ? ISSUE : COLLECT;
            end
            COLLECT: begin
                if (accept) begin
                    if (in_sop) begin
                        next = in_eop ? ISSUE : COLLECT;
                    end else if (full) begin
                        // An overflow byte that also ends the packet has nothing left to drop
                        err  = 1'b1;
                        next = in_eop ? IDLE : DROP;
                    end else if (in_eop) begin
                        next = ISSUE;
                    end
                end
            end
            DROP: begin
                if (accept) begin
                    if (in_sop)      next = in_eop ? ISSUE : COLLECT;
                    else if (in_eop) next = IDLE;
                end
            end
            ISSUE: begin
                next = WAIT_CRC;
            end
            WAIT_CRC: begin
                if (crc_done) begin
                    next = IDLE;
                end else if (expire) begin
                    err  = 1'b1;
                    next = IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_raw  <= '0;
            cnt       <= '0;
            tcnt      <= '0;
            res_valid <= 1'b0;
            res_crc   <= '0;
            res_len   <= '0;
        end else begin
            res_valid <= 1'b0;
            if (load) begin
                data_raw <= {{(DW-8){1'b0}}, in_data};
                cnt      <= 6'd1;
            end else if (shift) begin
                data_raw <= {data_raw[DW-9:0], in_data};
                cnt      <= cnt + 6'd1;
            end
            if (state == ISSUE)    tcnt <= '0;
            if (state == WAIT_CRC) tcnt <= tcnt + 1'b1;
            // cnt is frozen while waiting, so it still holds this packet's length
            if (state == WAIT_CRC && crc_done) begin
                res_crc   <= crc_in;
                res_len   <= cnt;
                res_valid <= 1'b1;
            end
        end
    end

endmodule
